// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared types and constants for the 4:1 select datapath.
//   sel_t        : 2-bit select code, {s1, s0}
//   SEL_D0..D3   : select codes for data inputs d0..d3
// -----------------------------------------------------------------------------
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_D0 = 2'b00;
  localparam sel_t SEL_D1 = 2'b01;
  localparam sel_t SEL_D2 = 2'b10;
  localparam sel_t SEL_D3 = 2'b11;

endpackage : mux_pkg

// File: rtl/mux4_core.sv
// -----------------------------------------------------------------------------
// mux4_core
// Purely combinational WIDTH-bit 4:1 select. Reusable wherever a plain
// select is needed; carries no state.
// Ports:
//   sel    : select code (SEL_D0..SEL_D3)
//   d0..d3 : data inputs
//   z      : selected data
// -----------------------------------------------------------------------------
module mux4_core
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  sel_t             sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] z
);

  // NOTE: all four codes of the 2-bit select are listed, so z is assigned on
  // every path and no latch is inferred; a default branch would be dead code.
  always_comb begin
    case (sel)
      SEL_D0: z = d0;
      SEL_D1: z = d1;
      SEL_D2: z = d2;
      SEL_D3: z = d3;
    endcase
  end

endmodule : mux4_core

// File: rtl/mux_4to1_dig.sv
// -----------------------------------------------------------------------------
// mux_4to1_dig
// Registered 4:1 data multiplexer with a valid qualifier. Fixed one-cycle
// latency from the sampling edge to y/out_valid; one sample per cycle, no
// backpressure.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset (priority over in_valid)
//   s1, s0    : select MSB / LSB
//   d0..d3    : WIDTH-bit data inputs
//   in_valid  : sample the selected data this cycle
//   y         : registered selected data, holds while in_valid is low
//   out_valid : high for one cycle after each accepted sample
// -----------------------------------------------------------------------------
module mux_4to1_dig
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1,
  input  logic             s0,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             out_valid
);

  sel_t             sel;
  logic [WIDTH-1:0] sel_data;

  assign sel = sel_t'({s1, s0});

  mux4_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .sel (sel),
    .d0  (d0),
    .d1  (d1),
    .d2  (d2),
    .d3  (d3),
    .z   (sel_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // Reset is synchronous and wins over in_valid, so an in-flight sample is
  // dropped. y holds when nothing is accepted; out_valid simply follows
  // in_valid by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y <= sel_data;
      end
    end
  end

endmodule : mux_4to1_dig

// File: tb/tb_mux_4to1_dig.sv
// -----------------------------------------------------------------------------
// tb_mux_4to1_dig
// Drives a WIDTH=1 and a WIDTH=8 instance from shared select/valid/reset.
// The reference model indexes an array of the driven data with the select
// value and applies the reset/valid rules directly.
// -----------------------------------------------------------------------------
module tb_mux_4to1_dig;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s1, s0;
  logic       in_valid;
  logic [0:0] n_d [4];
  logic [7:0] w_d [4];
  logic [0:0] n_y;
  logic [7:0] w_y;
  logic       n_ov, w_ov;

  int total = 0;
  int bad   = 0;

  // Model state.
  logic [0:0] exp_n_y;
  logic [7:0] exp_w_y;
  logic       exp_ov;

  always #5 clk = ~clk;

  mux_4to1_dig #(.WIDTH(1)) dut_n (
    .clk       (clk),
    .rst_n     (rst_n),
    .s1        (s1),
    .s0        (s0),
    .d0        (n_d[0]),
    .d1        (n_d[1]),
    .d2        (n_d[2]),
    .d3        (n_d[3]),
    .in_valid  (in_valid),
    .y         (n_y),
    .out_valid (n_ov)
  );

  mux_4to1_dig #(.WIDTH(8)) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .s1        (s1),
    .s0        (s0),
    .d0        (w_d[0]),
    .d1        (w_d[1]),
    .d2        (w_d[2]),
    .d3        (w_d[3]),
    .in_valid  (in_valid),
    .y         (w_y),
    .out_valid (w_ov)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".n_y"},  {7'd0, n_y}, {7'd0, exp_n_y});
    check({tag, ".n_ov"}, {7'd0, n_ov}, {7'd0, exp_ov});
    check({tag, ".w_y"},  w_y,          exp_w_y);
    check({tag, ".w_ov"}, {7'd0, w_ov}, {7'd0, exp_ov});
  endtask

  // One clock of stimulus. Inputs change on the falling edge; the outputs are
  // first checked to be unaffected by that change, then checked again just
  // after the rising edge against the model.
  // nbits[i] drives narrow d_i, wbytes[8*i +: 8] drives wide d_i.
  task automatic step(input string tag, input logic r, input logic v,
                      input int sel, input logic [3:0] nbits, input logic [31:0] wbytes);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    s1       = sel[1];
    s0       = sel[0];
    for (int i = 0; i < 4; i++) begin
      n_d[i] = nbits[i];
      w_d[i] = wbytes[8*i +: 8];
    end
    #1;
    if (exp_ov !== 1'bx) begin
      check({tag, ".hold_between_edges.n"}, {7'd0, n_y}, {7'd0, exp_n_y});
      check({tag, ".hold_between_edges.w"}, w_y, exp_w_y);
    end
    @(posedge clk);
    if (!r) begin
      exp_n_y = '0;
      exp_w_y = '0;
      exp_ov  = 1'b0;
    end else if (v) begin
      exp_n_y = n_d[sel];
      exp_w_y = w_d[sel];
      exp_ov  = 1'b1;
    end else begin
      exp_ov  = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  localparam logic [31:0] WIDE = {8'h00, 8'hFF, 8'h3C, 8'hA5};

  initial begin
    logic [3:0] one_hot;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    s1       = 1'b0;
    s0       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_d[i] = '0;
      w_d[i] = '0;
    end
    exp_n_y = 'x;
    exp_w_y = 'x;
    exp_ov  = 1'bx;

    // Reset held two cycles with in_valid high, then released.
    step("reset0",  1'b0, 1'b1, 0, 4'hF, WIDE);
    step("reset1",  1'b0, 1'b1, 0, 4'hF, WIDE);
    step("release", 1'b1, 1'b1, 0, 4'hF, WIDE);

    // Full select sweep: target input 1 with others 0, then the inverse.
    for (int s = 0; s < 4; s++) begin
      one_hot = 4'b0001 << s;
      step($sformatf("sweep_sel%0d_hi", s), 1'b1, 1'b1, s, one_hot,  WIDE);
      step($sformatf("sweep_sel%0d_lo", s), 1'b1, 1'b1, s, ~one_hot, WIDE);
    end

    // Hold: accept d3=1, then three idle cycles selecting d0=0.
    step("hold_load", 1'b1, 1'b1, 3, 4'b1000, WIDE);
    for (int k = 0; k < 3; k++)
      step($sformatf("hold_idle%0d", k), 1'b1, 1'b0, 0, 4'b1110, 32'h1122_3344);

    // Back-to-back alternating selects.
    for (int k = 0; k < 6; k++)
      step($sformatf("b2b%0d", k), 1'b1, 1'b1, (k % 2 == 0) ? 0 : 3, 4'b1000, WIDE);

    // Mid-stream reset for one cycle, then streaming resumes.
    step("mid_rst",    1'b0, 1'b1, 3, 4'b1000, WIDE);
    step("mid_resume", 1'b1, 1'b1, 3, 4'b1000, WIDE);
    step("mid_next",   1'b1, 1'b1, 1, 4'b0010, WIDE);

    // Wide data sweep.
    for (int s = 0; s < 4; s++)
      step($sformatf("wide_sel%0d", s), 1'b1, 1'b1, s, 4'b0101, WIDE);

    // Randomized traffic with occasional resets and idle cycles.
    for (int k = 0; k < 300; k++) begin
      step($sformatf("rand%0d", k),
           ($urandom_range(0, 31) != 0),
           ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 3)),
           4'($urandom),
           $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mux_4to1_dig
